// File: rtl/m0_sram_arb_pkg.sv
// -----------------------------------------------------------------------------
// m0_sram_arb_pkg
//   Shared constants and helpers for the m0_sram arbiter slice.
//   - SRAM data / byte-lane widths of the m0_sram macro
//   - default word-address width
//   - fixed requester indices of the default system (core0, core1, DMA)
//   - access-kind decode used by the arbiter (any byte enable = write)
// -----------------------------------------------------------------------------
package m0_sram_arb_pkg;

  localparam int SRAM_DW    = 32;
  localparam int SRAM_BE    = 4;
  localparam int AW_DEFAULT = 14;

  // Requester slots in the default three-master system.
  localparam int REQ_CORE0  = 0;
  localparam int REQ_CORE1  = 1;
  localparam int REQ_DMA    = 2;

  typedef enum logic {
    ACC_READ  = 1'b0,
    ACC_WRITE = 1'b1
  } acc_kind_e;

  // A partially set byte-enable vector still means "write"; there is no
  // mixed read/write access on this SRAM.
  function automatic acc_kind_e acc_kind(input logic [SRAM_BE-1:0] wen);
    return (|wen) ? ACC_WRITE : ACC_READ;
  endfunction

endpackage

// File: rtl/m0_rr_pick.sv
// -----------------------------------------------------------------------------
// m0_rr_pick
//   Purely combinational rotate-priority picker. Starting at start_i and
//   wrapping modulo N, the first set bit of valid_i wins.
//   Also intended for the DMA channel scheduler.
//
//   Parameters: N  number of candidates (2..8)
//               IW index width, >= clog2(N)
//   Ports:      valid_i [N]   candidate request vector
//               start_i [IW]  highest-priority index this cycle (< N)
//               grant_o [N]   one-hot winner, zero when nothing is valid
//               idx_o   [IW]  winner index (meaningful only when any_o)
//               any_o         at least one candidate valid
// -----------------------------------------------------------------------------
module m0_rr_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] start_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  localparam logic [IW:0] N_W = N[IW:0];

  logic [N-1:0] rot;   // valid_i rotated so that start_i sits at bit 0
  logic [IW:0]  off;   // distance of the winner from start_i
  logic [IW:0]  sum;   // start_i + off before the modulo-N wrap

  always_comb begin
    // NOTE: every variable gets a default at the top of a combinational
    // block, so no path through it can leave a value held (no latch).
    rot     = '0;
    off     = '0;
    sum     = '0;
    grant_o = '0;

    rot = N'({valid_i, valid_i} >> start_i);

    // Scan downwards so the lowest set bit (closest to start_i) is kept.
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) off = j[IW:0];
    end

    sum = {1'b0, start_i} + off;
    if (sum >= N_W) sum = sum - N_W;

    any_o = |valid_i;
    idx_o = sum[IW-1:0];

    for (int i = 0; i < N; i++) begin
      grant_o[i] = any_o && (idx_o == IW'(i));
    end
  end

endmodule

// File: rtl/m0_sram_arb.sv
// -----------------------------------------------------------------------------
// m0_sram_arb
//   Round-robin arbiter sharing one m0_sram (single-port, synchronous,
//   1-cycle read latency, byte-lane write enables) between NUM_REQ masters
//   (default: core0, core1, DMA). One access is granted per cycle; read
//   data comes back the following cycle tagged by a one-hot rd_valid.
//
//   Optional build macro: M0_SRAM_ARB_LOCK_EN
//     Defined   - a granted master holding req_lock keeps exclusive access
//                 (atomic RMW, DMA bursts) until it is granted with
//                 req_lock low or drops req_valid.
//     Undefined - req_lock is ignored and there is no lock state.
//
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     req_valid [N]  per-master request
//     req_ready [N]  per-master grant this cycle (one-hot or zero)
//     req_addr       flattened word addresses, master i at [i*AW +: AW]
//     req_wen        flattened byte enables, master i at [i*4 +: 4] (0 = read)
//     req_wdata      flattened write data, master i at [i*32 +: 32]
//     req_lock [N]   hold-grant request (lock build only)
//     rd_valid [N]   one-hot read-data valid, one cycle after a read grant
//     rd_data        read data, shared by all masters
//     SRAMCS/SRAMADDR/SRAMWEN/SRAMWDATA  command to m0_sram
//     SRAMRDATA      read data from m0_sram
// -----------------------------------------------------------------------------
module m0_sram_arb
  import m0_sram_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int AW      = AW_DEFAULT,
  parameter int IDW     = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*AW-1:0]      req_addr,
  input  logic [NUM_REQ*SRAM_BE-1:0] req_wen,
  input  logic [NUM_REQ*SRAM_DW-1:0] req_wdata,
  input  logic [NUM_REQ-1:0]         req_lock,
  output logic [NUM_REQ-1:0]         rd_valid,
  output logic [SRAM_DW-1:0]         rd_data,
  output logic                       SRAMCS,
  output logic [AW-1:0]              SRAMADDR,
  output logic [SRAM_BE-1:0]         SRAMWEN,
  output logic [SRAM_DW-1:0]         SRAMWDATA,
  input  logic [SRAM_DW-1:0]         SRAMRDATA
);

  localparam logic [IDW-1:0] LAST_IDX = IDW'(NUM_REQ - 1);

  // Arbitration state
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  // Read-return state: a read was granted last cycle, and by whom
  logic           rd_vld_q, rd_vld_d;
  logic [IDW-1:0] rd_id_q,  rd_id_d;

  // Current-cycle arbitration results
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     grant_idx;
  logic               grant_any;
  logic               lock_active;
  logic               grant_is_read;

  // Fields of the granted master, zero when nothing is granted
  logic [AW-1:0]      g_addr;
  logic [SRAM_BE-1:0] g_wen;
  logic [SRAM_DW-1:0] g_wdata;

  // ---------------------------------------------------------------------------
  // Optional lock
  // ---------------------------------------------------------------------------
`ifdef M0_SRAM_ARB_LOCK_EN
  logic               lock_owner_vld_q, lock_owner_vld_d;
  logic [IDW-1:0]     lock_owner_q,     lock_owner_d;
  logic [NUM_REQ-1:0] owner_mask;
  logic               g_lock;

  always_comb begin
    owner_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      owner_mask[i] = (lock_owner_q == IDW'(i));
    end
  end

  // A lock only binds while its owner keeps requesting; the cycle the owner
  // drops valid the others are arbitrated normally and the lock clears.
  assign lock_active = lock_owner_vld_q && |(req_valid & owner_mask);
  assign eligible    = lock_active ? (req_valid & owner_mask) : req_valid;
  assign g_lock      = |(grant & req_lock);

  always_comb begin
    lock_owner_vld_d = lock_owner_vld_q;
    lock_owner_d     = lock_owner_q;
    if (lock_active) begin
      // The owner is the only eligible requester, so it is granted here.
      if (!g_lock) lock_owner_vld_d = 1'b0;
    end else begin
      lock_owner_vld_d = 1'b0;
      if (grant_any && g_lock) begin
        lock_owner_vld_d = 1'b1;
        lock_owner_d     = grant_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_owner_vld_q <= 1'b0;
      lock_owner_q     <= '0;
    end else begin
      lock_owner_vld_q <= lock_owner_vld_d;
      lock_owner_q     <= lock_owner_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign lock_active = 1'b0;
  assign eligible    = req_valid;
`endif

  // ---------------------------------------------------------------------------
  // Round-robin pick
  // ---------------------------------------------------------------------------
  m0_rr_pick #(
    .N  (NUM_REQ),
    .IW (IDW)
  ) u_pick (
    .valid_i (eligible),
    .start_i (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .any_o   (grant_any)
  );

  // One-hot steering of the winner's fields onto the SRAM command.
  always_comb begin
    g_addr  = '0;
    g_wen   = '0;
    g_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        g_addr  = req_addr [i*AW      +: AW];
        g_wen   = req_wen  [i*SRAM_BE +: SRAM_BE];
        g_wdata = req_wdata[i*SRAM_DW +: SRAM_DW];
      end
    end
  end

  assign grant_is_read = grant_any && (acc_kind(g_wen) == ACC_READ);

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    // Locked grants leave the pointer alone so rotation resumes where it
    // stopped once the lock is released.
    if (grant_any && !lock_active) begin
      rr_ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    end

    rd_vld_d = grant_is_read;
    rd_id_d  = grant_is_read ? grant_idx : rd_id_q;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      rr_ptr_q <= '0;
      rd_vld_q <= 1'b0;
      rd_id_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      rd_vld_q <= rd_vld_d;
      rd_id_q  <= rd_id_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rd_valid[i] = rd_vld_q && (rd_id_q == IDW'(i));
    end
  end

  assign req_ready = grant;
  assign SRAMCS    = grant_any;
  assign SRAMADDR  = g_addr;
  assign SRAMWEN   = g_wen;
  assign SRAMWDATA = g_wdata;
  // The macro already delivers data one cycle after the grant; only the
  // one-hot rd_valid tells a master the word is its own.
  assign rd_data   = SRAMRDATA;

endmodule

// File: tb/tb_m0_sram_arb.sv
// -----------------------------------------------------------------------------
// tb_m0_sram_arb
//   Directed bench for m0_sram_arb with a behavioural m0_sram model.
//   Inputs are driven on the falling edge and outputs sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_m0_sram_arb;
  import m0_sram_arb_pkg::*;

  localparam int N  = 3;
  localparam int AW = 14;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid, req_ready, req_lock, rd_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*4-1:0]  req_wen;
  logic [N*32-1:0] req_wdata;
  logic [31:0]     rd_data, SRAMWDATA, SRAMRDATA;
  logic            SRAMCS;
  logic [AW-1:0]   SRAMADDR;
  logic [3:0]      SRAMWEN;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  m0_sram_arb #(.NUM_REQ(N), .AW(AW), .IDW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wen   (req_wen),
    .req_wdata (req_wdata),
    .req_lock  (req_lock),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .SRAMCS    (SRAMCS),
    .SRAMADDR  (SRAMADDR),
    .SRAMWEN   (SRAMWEN),
    .SRAMWDATA (SRAMWDATA),
    .SRAMRDATA (SRAMRDATA)
  );

  // Behavioural m0_sram with a preload port for setting up contents.
  logic [31:0]   mem [0:(1<<AW)-1];
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [31:0]   pre_data = '0;

  always @(posedge clk) begin
    if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end else if (SRAMCS) begin
      if (SRAMWEN != 4'b0000) begin
        for (int b = 0; b < 4; b++) begin
          if (SRAMWEN[b]) mem[SRAMADDR][b*8 +: 8] <= SRAMWDATA[b*8 +: 8];
        end
      end else begin
        SRAMRDATA <= mem[SRAMADDR];
      end
    end
  end

  // Expected-grant tables (hand-derived).
  localparam logic [2:0] FAIR_V [10] = '{3'b100, 3'b111, 3'b110, 3'b100, 3'b101,
                                         3'b100, 3'b110, 3'b101, 3'b101, 3'b100};
  localparam logic [2:0] FAIR_G [10] = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b001,
                                         3'b100, 3'b010, 3'b100, 3'b001, 3'b100};
`ifdef M0_SRAM_ARB_LOCK_EN
  localparam logic [2:0] LOCK_G [10] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100,
                                         3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
`else
  localparam logic [2:0] LOCK_G [10] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010,
                                         3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
`endif

  task automatic clear_reqs();
    req_valid = '0;
    req_lock  = '0;
    req_addr  = '0;
    req_wen   = '0;
    req_wdata = '0;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a,
                         input logic [3:0] w, input logic [31:0] d);
    req_valid[i]          = 1'b1;
    req_addr[i*AW +: AW]  = a;
    req_wen[i*4 +: 4]     = w;
    req_wdata[i*32 +: 32] = d;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_en   = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(negedge clk);
    pre_en   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_reqs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    total++; if (rd_valid !== 3'b000) begin bad++; $display("FAIL reset_rd_valid: got %b want 000", rd_valid); end
    total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL reset_ready: got %b want 000", req_ready); end
    total++; if (SRAMCS !== 1'b0) begin bad++; $display("FAIL reset_cs: got %b want 0", SRAMCS); end
    total++; if ({SRAMADDR, SRAMWEN, SRAMWDATA} !== '0) begin bad++;
      $display("FAIL reset_cmd: addr=%h wen=%b wdata=%h want all zero", SRAMADDR, SRAMWEN, SRAMWDATA); end
    rst_n = 1'b1;
    @(negedge clk); #1;
    total++; if (SRAMCS !== 1'b0 || req_ready !== 3'b000) begin bad++;
      $display("FAIL idle_after_reset: cs=%b ready=%b want 0/000", SRAMCS, req_ready); end
  endtask

  task automatic test_single_read();
    preload(14'h0010, 32'hDEADBEEF);
    @(negedge clk); set_req(1, 14'h0010, 4'b0000, 32'h0); #1;
    total++; if (req_ready !== 3'b010) begin bad++; $display("FAIL read_ready: got %b want 010", req_ready); end
    total++; if (SRAMCS !== 1'b1 || SRAMADDR !== 14'h0010 || SRAMWEN !== 4'b0000) begin bad++;
      $display("FAIL read_cmd: cs=%b addr=%h wen=%b want 1/0010/0000", SRAMCS, SRAMADDR, SRAMWEN); end
    @(negedge clk); clear_reqs(); #1;
    total++; if (rd_valid !== 3'b010) begin bad++; $display("FAIL read_rd_valid: got %b want 010", rd_valid); end
    total++; if (rd_data !== 32'hDEADBEEF) begin bad++; $display("FAIL read_data: got %h want deadbeef", rd_data); end
    @(negedge clk); #1;
    total++; if (rd_valid !== 3'b000) begin bad++; $display("FAIL read_pulse_len: got %b want 000", rd_valid); end
  endtask

  task automatic test_byte_write();
    preload(14'h0004, 32'h11223344);
    @(negedge clk); set_req(0, 14'h0004, 4'b0100, 32'h00AB0000); #1;
    total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL write_ready: got %b want 001", req_ready); end
    total++; if (SRAMWEN !== 4'b0100 || SRAMWDATA !== 32'h00AB0000) begin bad++;
      $display("FAIL write_cmd: wen=%b wdata=%h want 0100/00ab0000", SRAMWEN, SRAMWDATA); end
    @(negedge clk); clear_reqs(); #1;
    total++; if (rd_valid !== 3'b000) begin bad++; $display("FAIL write_no_rd_valid: got %b want 000", rd_valid); end
    @(negedge clk); set_req(0, 14'h0004, 4'b0000, 32'h0); #1;
    total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL readback_ready: got %b want 001", req_ready); end
    @(negedge clk); clear_reqs(); #1;
    total++; if (rd_valid !== 3'b001) begin bad++; $display("FAIL readback_rd_valid: got %b want 001", rd_valid); end
    total++; if (rd_data !== 32'h11AB3344) begin bad++; $display("FAIL readback_data: got %h want 11ab3344", rd_data); end
  endtask

  task automatic test_contention();
    logic [2:0]  exp_g, exp_r;
    logic [31:0] exp_d;
    do_reset();
    for (int i = 0; i < N; i++) preload(14'h0100 + 14'(i), 32'hA0000000 + 32'(i));
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) for (int i = 0; i < N; i++) set_req(i, 14'h0100 + 14'(i), 4'b0000, 32'h0);
      #1;
      exp_g = 3'b001 << (c % 3);
      total++; if (req_ready !== exp_g) begin bad++; $display("FAIL contention_grant c=%0d: got %b want %b", c, req_ready, exp_g); end
      total++; if (SRAMADDR !== 14'h0100 + 14'(c % 3)) begin bad++;
        $display("FAIL contention_addr c=%0d: got %h want %h", c, SRAMADDR, 14'h0100 + 14'(c % 3)); end
      exp_r = (c == 0) ? 3'b000 : (3'b001 << ((c - 1) % 3));
      total++; if (rd_valid !== exp_r) begin bad++; $display("FAIL contention_rd_valid c=%0d: got %b want %b", c, rd_valid, exp_r); end
      if (c > 0) begin
        exp_d = 32'hA0000000 + 32'((c - 1) % 3);
        total++; if (rd_data !== exp_d) begin bad++; $display("FAIL contention_data c=%0d: got %h want %h", c, rd_data, exp_d); end
      end
    end
    @(negedge clk); clear_reqs(); #1;
    total++; if (rd_valid !== 3'b100) begin bad++; $display("FAIL contention_last_rd_valid: got %b want 100", rd_valid); end
  endtask

  task automatic test_fairness();
    logic [2:0] prev_g;
    int         wait0;
    prev_g = '0;
    wait0  = 0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      clear_reqs();
      for (int i = 0; i < N; i++) if (FAIR_V[c][i]) set_req(i, 14'h0020, 4'b0000, 32'h0);
      #1;
      total++; if (req_ready !== FAIR_G[c]) begin bad++; $display("FAIL fair_grant c=%0d: got %b want %b", c, req_ready, FAIR_G[c]); end
      total++; if (rd_valid !== ((c == 0) ? 3'b000 : FAIR_G[(c == 0) ? 0 : c - 1])) begin bad++;
        $display("FAIL fair_rd_valid c=%0d: got %b", c, rd_valid); end
      if (req_valid[0] && !req_ready[0]) wait0++; else wait0 = 0;
      total++; if (wait0 > 2) begin bad++; $display("FAIL fair_wait0 c=%0d: waited %0d want <=2", c, wait0); end
      if (c > 0 && (req_valid & ~req_ready) != 3'b000) begin
        total++; if (req_ready === prev_g) begin bad++;
          $display("FAIL fair_repeat c=%0d: got %b twice while %b waiting", c, req_ready, req_valid & ~req_ready); end
      end
      prev_g = req_ready;
    end
    @(negedge clk); clear_reqs();
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk); set_req(1, 14'h0010, 4'b0000, 32'h0); #1;
    total++; if (req_ready !== 3'b010) begin bad++; $display("FAIL midrst_grant: got %b want 010", req_ready); end
    @(posedge clk); #1;
    total++; if (rd_valid !== 3'b010) begin bad++; $display("FAIL midrst_pending: got %b want 010", rd_valid); end
    rst_n = 1'b0;
    clear_reqs();
    #1;
    total++; if (rd_valid !== 3'b000) begin bad++; $display("FAIL midrst_discard: got %b want 000", rd_valid); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      total++; if (rd_valid !== 3'b000) begin bad++; $display("FAIL midrst_no_pulse c=%0d: got %b want 000", c, rd_valid); end
    end
    @(negedge clk);
    set_req(0, 14'h0010, 4'b0000, 32'h0);
    set_req(2, 14'h0010, 4'b0000, 32'h0);
    #1;
    total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL midrst_rr_ptr: got %b want 001", req_ready); end
    @(negedge clk); clear_reqs();
  endtask

  task automatic test_lock();
    do_reset();
    @(negedge clk);
    for (int i = 0; i < N; i++) set_req(i, 14'h0040 + 14'(i), 4'b0000, 32'h0);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      req_lock = (c < 5) ? 3'b100 : 3'b000;
      #1;
      total++; if (req_ready !== LOCK_G[c]) begin bad++; $display("FAIL lock_grant c=%0d: got %b want %b", c, req_ready, LOCK_G[c]); end
    end
    @(negedge clk); clear_reqs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_reqs();
    test_reset();
    test_single_read();
    test_byte_write();
    test_contention();
    test_fairness();
    test_reset_mid_read();
    test_lock();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
